// File: rtl/roadid_ctrl_pkg.sv
// Shared definitions for the road-ID controller: fit-side FSM states and
// default sizing of the combination-count path and the best-road FIFO.
package roadid_ctrl_pkg;

  localparam int NCOMB_W_DEF    = 8;
  localparam int QDEPTH_DEF     = 16;
  localparam int BEST_DEPTH_DEF = 16;

  // Fit-side sequencing: wait for a queued road, load its count, run its fits.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } fit_state_t;

endpackage

// File: rtl/roadid_ctrl_ncomb_queue.sv
// Synchronous FIFO holding the combination count of every road whose ID sits
// in the road-ID input FIFO. The head is visible combinationally so the
// consumer can use it in the cycle it pops. Push and pop in the same cycle
// both take effect, also when full (the pop frees the slot being written).
module roadid_ncomb_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   CLOCK,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Storage array: written on every accepted push, never reset.
  always_ff @(posedge CLOCK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks both sides.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/roadid_ctrl.sv
// Road-ID controller. Accepts roads (ID into an external FIFO, combination
// count into a local queue), walks the fit results of each road's
// combinations, and pushes roads with at least one passing fit into the
// downstream best FIFO, whose occupancy it tracks and drains.
//
// Handshakes: a transfer happens on a rising CLOCK edge where valid and ready
// are both high; ready never depends on valid, and valid/data are held by the
// source until the transfer.
module roadid_ctrl
  import roadid_ctrl_pkg::*;
#(
  parameter int NCOMB_W    = NCOMB_W_DEF,
  parameter int QDEPTH     = QDEPTH_DEF,
  parameter int BEST_DEPTH = BEST_DEPTH_DEF
) (
  input  logic                          CLOCK,
  input  logic                          reset,
  input  logic                          road_valid,
  input  logic [NCOMB_W-1:0]            road_ncomb,
  output logic                          road_ready,
  input  logic                          fifo_roadid_afull,
  output logic                          CE,
  output logic                          roadid_we,
  input  logic                          fit_valid,
  input  logic                          fit_pass,
  output logic                          fit_ready,
  output logic                          last_comb,
  output logic                          best,
  input  logic                          out_ready,
  output logic                          roadid_re,
  output logic                          out_valid,
  output logic [$clog2(BEST_DEPTH):0]   best_count,
  output fit_state_t                    state_dbg
);

  localparam int BC_W = $clog2(BEST_DEPTH) + 1;
  localparam int QC_W = $clog2(QDEPTH) + 1;

  logic               accept;
  logic               we_q;
  logic [NCOMB_W-1:0] ncomb_q;

  logic               q_pop;
  logic               q_full;
  logic               q_empty;
  logic [NCOMB_W-1:0] q_head;
  logic [QC_W-1:0]    q_count;

  fit_state_t         state;
  logic [NCOMB_W-1:0] rem;
  logic               pass_q;
  logic               fit_acc;
  logic               fit_last;

  logic [BC_W-1:0]    bc;
  logic               out_valid_q;

  // A road accepted last cycle still has its count in flight to the queue, so
  // the last free slot is treated as taken while that push is pending.
  assign road_ready = !reset && !fifo_roadid_afull && !q_full &&
                      !(we_q && (q_count == QC_W'(QDEPTH - 1)));
  assign accept     = road_valid && road_ready;
  assign CE         = accept;
  assign roadid_we  = we_q;

  // Road ID is registered by CE; one cycle later it and its count are written.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      we_q    <= 1'b0;
      ncomb_q <= '0;
    end else begin
      we_q <= accept;
      if (accept) ncomb_q <= road_ncomb;
    end
  end

  roadid_ncomb_queue #(
    .W     (NCOMB_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .CLOCK     (CLOCK),
    .reset     (reset),
    .push      (we_q),
    .push_data (ncomb_q),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Fits are only taken while the best FIFO has room for a possible push.
  assign fit_ready = !reset && (state == ST_RUN) && (bc < BC_W'(BEST_DEPTH));
  assign fit_acc   = fit_valid && fit_ready;
  assign fit_last  = fit_acc && (rem == NCOMB_W'(1));
  assign q_pop     = !reset && (state == ST_LOAD);
  // A road with zero combinations retires straight out of LOAD, never best.
  assign last_comb = (q_pop && (q_head == '0)) || fit_last;
  assign best      = fit_last && (pass_q || fit_pass);
  assign state_dbg = state;

  // Fit-side FSM: load a road's count, count down accepted fits, retire the road.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state  <= ST_IDLE;
      rem    <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!q_empty) state <= ST_LOAD;
        end
        ST_LOAD: begin
          rem    <= q_head;
          pass_q <= 1'b0;
          state  <= (q_head == '0) ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          if (fit_acc) begin
            rem    <= rem - 1'b1;
            pass_q <= pass_q || fit_pass;
            if (fit_last) state <= q_empty ? ST_IDLE : ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Best FIFO is not first-word fall-through: data appears the cycle after the read.
  assign roadid_re  = !reset && (bc != '0) && out_ready;
  assign out_valid  = out_valid_q;
  assign best_count = bc;

  // Best FIFO occupancy: a simultaneous push and read cancel out.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      bc          <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= roadid_re;
      case ({best, roadid_re})
        2'b10:   bc <= bc + 1'b1;
        2'b01:   bc <= bc - 1'b1;
        default: bc <= bc;
      endcase
    end
  end

endmodule
